// File: rtl/regfile_wr_arbiter_if.sv
// Handshake and register-file write-port bundle for regfile_wr_arbiter.
// master = requester/control side, slave = the arbiter.
interface regfile_wr_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  clr_req;
    logic                  req0_valid;
    logic [ADDR_WIDTH-1:0] req0_addr;
    logic [DATA_WIDTH-1:0] req0_data;
    logic                  req0_ready;
    logic                  req1_valid;
    logic [ADDR_WIDTH-1:0] req1_addr;
    logic [DATA_WIDTH-1:0] req1_data;
    logic                  req1_ready;
    logic                  rf_we;
    logic [ADDR_WIDTH-1:0] rf_addr;
    logic [DATA_WIDTH-1:0] rf_wdata;
    logic                  init_done;
    logic [15:0]           stall_cnt;

    modport master (
        output clr_req,
        output req0_valid, req0_addr, req0_data,
        input  req0_ready,
        output req1_valid, req1_addr, req1_data,
        input  req1_ready,
        input  rf_we, rf_addr, rf_wdata, init_done, stall_cnt
    );

    modport slave (
        input  clr_req,
        input  req0_valid, req0_addr, req0_data,
        output req0_ready,
        input  req1_valid, req1_addr, req1_data,
        output req1_ready,
        output rf_we, rf_addr, rf_wdata, init_done, stall_cnt
    );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Register-file write-port owner: zero sweep after reset / clear request,
// then round-robin sharing between ALU writeback (0) and load return (1).
module regfile_wr_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_REGS   = 32
) (
    input logic                CLK,
    input logic                RST,
    regfile_wr_arbiter_if.slave bus
);
    localparam logic [0:0] CLEAR = 1'b0;
    localparam logic [0:0] RUN   = 1'b1;

    localparam logic [ADDR_WIDTH-1:0] LAST_REG = ADDR_WIDTH'(NUM_REGS - 1);

    if (NUM_REGS < 2 || NUM_REGS > (1 << ADDR_WIDTH)) begin : g_bad_num_regs
        $error("regfile_wr_arbiter: NUM_REGS out of range");
    end

    logic [0:0]            state;
    logic [ADDR_WIDTH-1:0] cnt;
    logic                  last_grant;
    logic                  run_ok;
    logic                  grant0;
    logic                  grant1;
    logic                  stalled;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;

    // A clear request in RUN pre-empts any grant in that same cycle.
    assign run_ok = (state == RUN) && !bus.clr_req;
    assign grant0 = run_ok && bus.req0_valid && (!bus.req1_valid || last_grant);
    assign grant1 = run_ok && bus.req1_valid && (!bus.req0_valid || !last_grant);

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;

    assign stalled = (bus.req0_valid && !grant0) || (bus.req1_valid && !grant1);

    assign sel_addr = grant1 ? bus.req1_addr : bus.req0_addr;
    assign sel_data = grant1 ? bus.req1_data : bus.req0_data;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            bus.stall_cnt <= '0;
        end else if (stalled && bus.stall_cnt != 16'hFFFF) begin
            bus.stall_cnt <= bus.stall_cnt + 16'd1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state         <= CLEAR;
            cnt           <= '0;
            last_grant    <= 1'b1;
            bus.rf_we     <= 1'b0;
            bus.rf_addr   <= '0;
            bus.rf_wdata  <= '0;
            bus.init_done <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    if (bus.clr_req) begin
                        cnt       <= '0;
                        bus.rf_we <= 1'b0;
                    end else begin
                        bus.rf_we    <= 1'b1;
                        bus.rf_addr  <= cnt;
                        bus.rf_wdata <= '0;
                        cnt          <= cnt + 1'b1;
                        if (cnt == LAST_REG) begin
                            state         <= RUN;
                            bus.init_done <= 1'b1;
                        end
                    end
                end
                default: begin
                    if (bus.clr_req) begin
                        state         <= CLEAR;
                        cnt           <= '0;
                        bus.init_done <= 1'b0;
                        bus.rf_we     <= 1'b0;
                    end else if (grant0 || grant1) begin
                        last_grant <= grant1;
                        // Register 0 is hardwired: accept, but never write it.
                        if (sel_addr != '0) begin
                            bus.rf_we    <= 1'b1;
                            bus.rf_addr  <= sel_addr;
                            bus.rf_wdata <= sel_data;
                        end else begin
                            bus.rf_we <= 1'b0;
                        end
                    end else begin
                        bus.rf_we <= 1'b0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Scoreboard bench for regfile_wr_arbiter: expected writes are queued by the
// stimulus, and a negedge monitor checks every rf_we cycle against the queue.
module tb_regfile_wr_arbiter;
    logic CLK = 1'b0;
    logic RST = 1'b0;

    regfile_wr_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

    regfile_wr_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_REGS(32)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t sb[$];
    int  checks = 0;
    int  errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
        sb.push_back({a, d});
    endtask

    task automatic expect_sweep(input int n);
        for (int i = 0; i < n; i++) expect_wr(5'(i), 32'h0);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                         input logic v1, input logic [4:0] a1, input logic [31:0] d1);
        bus.req0_valid = v0; bus.req0_addr = a0; bus.req0_data = d0;
        bus.req1_valid = v1; bus.req1_addr = a1; bus.req1_data = d1;
        #1;
    endtask

    task automatic chk_ready(input string name, input logic r0, input logic r1);
        chk({name, ".ready0"}, 32'(bus.req0_ready), 32'(r0));
        chk({name, ".ready1"}, 32'(bus.req1_ready), 32'(r1));
    endtask

    // Monitor: every write the DUT presents must match the oldest expected one.
    always @(negedge CLK) begin
        if (RST && bus.rf_we) begin
            wr_t e;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0d data %0h expected none at %0t",
                         bus.rf_addr, bus.rf_wdata, $time);
            end else begin
                e = sb.pop_front();
                chk("wr_addr", 32'(bus.rf_addr), 32'(e.addr));
                chk("wr_data", bus.rf_wdata, e.data);
            end
        end
    end

    initial begin
        bus.clr_req = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

        // Reset state
        repeat (3) @(negedge CLK);
        chk("rst.rf_we", 32'(bus.rf_we), 32'h0);
        chk("rst.rf_addr", 32'(bus.rf_addr), 32'h0);
        chk("rst.rf_wdata", bus.rf_wdata, 32'h0);
        chk("rst.init_done", 32'(bus.init_done), 32'h0);
        chk("rst.stall_cnt", 32'(bus.stall_cnt), 32'h0);
        chk_ready("rst", 1'b0, 1'b0);

        // Power-on sweep: 32 zero writes, init_done on edge 32
        expect_sweep(32);
        RST = 1'b1;
        repeat (31) step();
        chk("sweep.init_before", 32'(bus.init_done), 32'h0);
        step();
        chk("sweep.init_edge32", 32'(bus.init_done), 32'h1);

        // Tie and alternation: 0,1,0,1
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 5'd5, 32'hAAAA0000, 1'b1, 5'd6, 32'h5555FFFF);
            if (i % 2 == 0) begin
                chk_ready("tie", 1'b1, 1'b0);
                expect_wr(5'd5, 32'hAAAA0000);
            end else begin
                chk_ready("tie", 1'b0, 1'b1);
                expect_wr(5'd6, 32'h5555FFFF);
            end
            step();
        end
        chk("tie.stall_cnt", 32'(bus.stall_cnt), 32'd4);

        // Single requester 1, then a tie goes to requester 0
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h00000099);
            chk_ready("single", 1'b0, 1'b1);
            expect_wr(5'd9, 32'h00000099);
            step();
        end
        drive(1'b1, 5'd3, 32'h00000033, 1'b1, 5'd9, 32'h00000099);
        chk_ready("after_single", 1'b1, 1'b0);
        expect_wr(5'd3, 32'h00000033);
        step();
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h00000099);
        chk_ready("after_single2", 1'b0, 1'b1);
        expect_wr(5'd9, 32'h00000099);
        step();
        chk("single.stall_cnt", 32'(bus.stall_cnt), 32'd5);

        // Register 0: accepted, no write, but counts as the last grant
        drive(1'b1, 5'd0, 32'h00001234, 1'b0, 5'd0, 32'h0);
        chk_ready("reg0", 1'b1, 1'b0);
        step();
        chk("reg0.rf_we", 32'(bus.rf_we), 32'h0);
        drive(1'b1, 5'd7, 32'h00000077, 1'b1, 5'd8, 32'h00000088);
        chk_ready("reg0_tie", 1'b0, 1'b1);
        expect_wr(5'd8, 32'h00000088);
        step();
        drive(1'b1, 5'd7, 32'h00000077, 1'b0, 5'd0, 32'h0);
        chk_ready("reg0_tie2", 1'b1, 1'b0);
        expect_wr(5'd7, 32'h00000077);
        step();
        chk("reg0.stall_cnt", 32'(bus.stall_cnt), 32'd6);

        // clr_req mid-stream with req0 pending
        drive(1'b1, 5'd10, 32'h000000A0, 1'b0, 5'd0, 32'h0);
        bus.clr_req = 1'b1;
        #1;
        chk_ready("clr", 1'b0, 1'b0);
        expect_sweep(32);
        step();
        bus.clr_req = 1'b0;
        chk("clr.init_done", 32'(bus.init_done), 32'h0);
        chk("clr.rf_we", 32'(bus.rf_we), 32'h0);
        repeat (31) step();
        chk_ready("clr_sweep31", 1'b0, 1'b0);
        step();
        chk("clr.init_again", 32'(bus.init_done), 32'h1);
        chk_ready("clr_done", 1'b1, 1'b0);
        chk("clr.stall_cnt", 32'(bus.stall_cnt), 32'd39);
        expect_wr(5'd10, 32'h000000A0);
        step();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        step();
        chk("clr.sb_empty", 32'(sb.size()), 32'd0);

        // Async reset at cnt=10: the write from edge 10 (addr 9) is lost
        bus.clr_req = 1'b1;
        step();
        bus.clr_req = 1'b0;
        expect_sweep(9);
        repeat (10) step();
        #1;
        RST = 1'b0;
        #1;
        chk("arst.rf_we", 32'(bus.rf_we), 32'h0);
        chk("arst.init_done", 32'(bus.init_done), 32'h0);
        chk("arst.stall_cnt", 32'(bus.stall_cnt), 32'h0);
        chk("arst.sb_empty", 32'(sb.size()), 32'd0);
        expect_sweep(32);
        #10;
        RST = 1'b1;
        repeat (32) step();
        chk("arst.init_done_after", 32'(bus.init_done), 32'h1);
        repeat (2) step();
        chk("arst.sb_empty_end", 32'(sb.size()), 32'd0);
        chk("arst.rf_we_idle", 32'(bus.rf_we), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_wr_arbiter.md
# regfile_wr_arbiter

Write-port controller for the 32-entry MIPS register file. It owns the file's single write port (write address, write data, write enable). After every reset, and on a software clear request, it sweeps zeros into every register. It then shares the write port between two writeback requesters: requester 0 is ALU writeback and requester 1 is load-data return. Arbitration is round-robin, and writes to register 0 are suppressed.

## Interface
- DATA_WIDTH, 32, width of write data
- ADDR_WIDTH, 5, register address width
- NUM_REGS, 32, registers cleared by the sweep; must satisfy 2 ≤ NUM_REGS ≤ 2^ADDR_WIDTH
- CLK  in  1  clock, rising edge
- RST  in  1  reset, asynchronous, active-low
- clr_req  in  1  single-cycle pulse; restarts the clear sweep
- req0_valid  in  1  requester 0 has a write pending
- req0_addr  in  ADDR_WIDTH  requester 0 destination register
- req0_data  in  DATA_WIDTH  requester 0 write data
- req0_ready  out  1  requester 0 accepted this cycle (combinational)
- req1_valid, req1_addr, req1_data, req1_ready  same as requester 0, for requester 1
- rf_we  out  1  register-file write enable (registered)
- rf_addr  out  ADDR_WIDTH  register-file write address (registered)
- rf_wdata  out  DATA_WIDTH  register-file write data (registered)
- init_done  out  1  high once a clear sweep has completed
- stall_cnt  out  16  saturating count of cycles in which a valid request was not accepted

## Operation
- States: CLEAR and RUN. Reset enters CLEAR with the sweep counter at 0.
- CLEAR:
  - Each cycle, register rf_we=1, rf_addr=cnt, rf_wdata=0, then increment cnt.
  - When cnt==NUM_REGS-1, go to RUN and set init_done=1 on the same edge.
  - req0_ready and req1_ready are held at 0.
- RUN, grant selection:
  - Only requester 0 valid: grant 0. Only requester 1 valid: grant 1.
  - Both valid: grant the requester that was not granted last (last_grant).
  - A transfer occurs when valid && ready. On a transfer, last_grant takes the granted index.
  - At most one grant per cycle.
- RUN, write-port outputs:
  - On the edge after a transfer: rf_we=1, rf_addr and rf_wdata take the granted requester's values.
  - With no transfer: rf_we=0, and rf_addr/rf_wdata hold their previous values.
- Register 0: a request to address 0 is accepted (ready=1) and updates last_grant, but rf_we stays 0 for it.
- clr_req:
  - In RUN: go to CLEAR, cnt=0, init_done=0. No grant is issued in that cycle.
  - In CLEAR: restart the sweep at cnt=0.
- stall_cnt: increments by 1 in any cycle where (req0_valid && !req0_ready) || (req1_valid && !req1_ready). This includes CLEAR cycles. It saturates at 0xFFFF and is cleared only by RST.
- Requesters must hold valid/addr/data stable until ready. The block does not check this.

## Timing
- Reset values: rf_we=0, rf_addr=0, rf_wdata=0, init_done=0, stall_cnt=0, req0_ready=0, req1_ready=0. Internal: state=CLEAR, cnt=0, last_grant=1, so requester 0 wins the first tie.
- RST assertion mid-sweep or mid-RUN forces all reset values immediately, without waiting for CLK. Any in-flight write is lost.
- After RST release:
  - Clear writes occur on edges 1 through NUM_REGS, covering addresses 0 through NUM_REGS-1.
  - init_done rises on edge NUM_REGS.
  - The earliest possible acceptance is the cycle after edge NUM_REGS.
- Latency: acceptance in cycle N gives rf_we high during cycle N+1, so the write lands at the end of N+1.
- Throughput: one write per cycle.
- Read-after-write bypass is not provided. Consumers must not read a register in the same cycle it is being written.
- The ready outputs are combinational from valid, state and last_grant. They do not depend on req*_data or req*_addr.

## Test plan
- Reset sweep, NUM_REGS=32: release RST, no requests → rf_we high for 32 consecutive edges; rf_addr steps 0..31 with rf_wdata=0; init_done=1 on edge 32; then rf_we=0.
- Tie and alternation: after init, hold both valid (req0 addr 5 data 0xAAAA0000, req1 addr 6 data 0x5555FFFF) for 4 cycles → ready sequence 0,1,0,1. rf_addr then follows 5,6,5,6 one cycle later.
- Single requester: only req1_valid with addr 9 for 3 cycles → req1_ready=1 every cycle. Then both valid → requester 0 wins.
- Register 0: req0 addr 0 data 0x1234 accepted → req0_ready=1, rf_we stays 0. Next tie → grant goes to requester 1.
- clr_req mid-stream: pulse while req0 is valid → no grant that cycle; init_done drops; 32-cycle sweep reruns. During the sweep stall_cnt increments once per cycle; req0 is accepted the cycle after edge 32 of the sweep.
- Async reset mid-sweep: assert RST at cnt=10 between clock edges → rf_we=0 and init_done=0 immediately. After release, the sweep restarts at address 0.
